// File: rtl/alu_seq.sv
// Command sequencer for the matrix-multiplier ALU: issues single ops or MAC steps,
// waits out the ALU result/zero-flag latency, and returns a held response.
module alu_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_last,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic [1:0]  alu_z
);

  typedef enum logic [2:0] {
    S_IDLE, S_W1, S_W2, S_W3, S_MACADD, S_MW1, S_MW2, S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        mac_q, mac_d;
  logic        last_q, last_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] in1_q, in1_d;
  logic [15:0] in2_q, in2_d;
  logic [2:0]  op_q, op_d;

  logic unused_alu_z;
  assign unused_alu_z = alu_z[1];

  always_comb begin
    state_d    = state_q;
    mac_d      = mac_q;
    last_d     = last_q;
    acc_d      = acc_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    op_d       = op_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          mac_d   = (cmd_op == 3'd5);
          last_d  = cmd_last;
          state_d = S_W1;
          case (cmd_op)
            3'd0, 3'd2: begin
              in1_d = cmd_a;
              in2_d = cmd_b;
              op_d  = cmd_op;
            end
            3'd1: begin
              // ALU computes in2 - in1, so operands go in swapped
              in1_d = cmd_b;
              in2_d = cmd_a;
              op_d  = cmd_op;
            end
            3'd3: begin
              if (cmd_b == '0) begin
                rsp_data_d = '1;
                rsp_zero_d = 1'b0;
                rsp_err_d  = 1'b1;
                state_d    = S_RESP;
              end else begin
                in1_d = cmd_a;
                in2_d = cmd_b;
                op_d  = cmd_op;
              end
            end
            3'd4: begin
              in1_d = '0;
              in2_d = cmd_a;
              op_d  = cmd_op;
            end
            3'd5: begin
              in1_d = cmd_a;
              in2_d = cmd_b;
              op_d  = 3'd2;
            end
            default: begin
              rsp_data_d = '1;
              rsp_zero_d = 1'b0;
              rsp_err_d  = 1'b1;
              state_d    = S_RESP;
            end
          endcase
        end
      end
      S_W1: state_d = S_W2;
      S_W2: begin
        if (mac_q) begin
          in1_d   = alu_out;
          in2_d   = acc_q;
          op_d    = 3'd0;
          state_d = S_MACADD;
        end else begin
          rsp_data_d = alu_out;
          state_d    = S_W3;
        end
      end
      S_W3: begin
        rsp_zero_d = alu_z[0];
        state_d    = S_RESP;
      end
      S_MACADD: state_d = S_MW1;
      S_MW1: begin
        acc_d = alu_out;
        if (last_q) begin
          rsp_data_d = alu_out;
          state_d    = S_MW2;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MW2: begin
        rsp_zero_d = alu_z[0];
        acc_d      = '0;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_err_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mac_q      <= 1'b0;
      last_q     <= 1'b0;
      acc_q      <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
      in1_q      <= '0;
      in2_q      <= '0;
      op_q       <= '0;
    end else begin
      state_q    <= state_d;
      mac_q      <= mac_d;
      last_q     <= last_d;
      acc_q      <= acc_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      op_q       <= op_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !reset;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign alu_in1   = in1_q;
  assign alu_in2   = in2_q;
  assign alu_op    = op_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU, vector table for single ops, scoreboard queue
// for responses, and hand sequences for MAC chains, backpressure and mid-op reset.
module tb_alu_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic        cmd_last = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_err;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic [2:0]  alu_op;
  logic [15:0] alu_out = '0;
  logic [1:0]  alu_z = '0;

  alu_seq dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_last(cmd_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z)
  );

  always #5 clock = ~clock;

  // Reference ALU: result registered once, zero flag one cycle behind it.
  logic [15:0] alu_f;
  always_comb begin
    alu_f = '0;
    case (alu_op)
      3'd0: alu_f = alu_in1 + alu_in2;
      3'd1: alu_f = alu_in2 - alu_in1;
      3'd2: alu_f = alu_in1 * alu_in2;
      3'd3: alu_f = (alu_in2 == '0) ? 16'hFFFF : alu_in1 / alu_in2;
      3'd4: alu_f = alu_in2;
      default: alu_f = '0;
    endcase
  end
  always_ff @(posedge clock) begin
    alu_out <= alu_f;
    alu_z   <= {1'b0, (alu_out == '0)};
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic [15:0] data; logic zero; logic err; } rsp_t;
  rsp_t sb[$];

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        touch;
    logic [15:0] in1, in2;
    logic [2:0]  aop;
    logic [15:0] data;
    logic        zero, err;
    int          lat;
  } vec_t;
  vec_t vt[11];

  // Returns #1 after the handshake edge.
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic last);
    int n;
    @(negedge clock);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_last = last; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("accept_in_time", (n < 100), 1);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts edges from the handshake edge (inclusive) until rsp_valid, then pops and accepts.
  task automatic wait_rsp(input string name, output int lat);
    rsp_t e;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clock);
      #1 lat++;
    end
    if (!rsp_valid) begin
      check({name, "_timeout"}, 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      check({name, "_unexpected_rsp"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    check({name, "_data"}, rsp_data, e.data);
    check({name, "_zero"}, rsp_zero, e.zero);
    check({name, "_err"}, rsp_err, e.err);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    check({name, "_valid_clr"}, rsp_valid, 0);
    check({name, "_err_clr"}, rsp_err, 0);
  endtask

  task automatic wait_ready(input string name, output int n);
    n = 1;
    while (!cmd_ready && n < 100) begin
      @(posedge clock);
      #1 n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [15:0] p1, p2;
    logic [2:0]  pop;

    vt[0]  = '{3'd0, 16'd3,     16'd4,      1'b1, 16'd3,  16'd4,  3'd0, 16'd7,      1'b0, 1'b0, 4};
    vt[1]  = '{3'd1, 16'd5,     16'd5,      1'b1, 16'd5,  16'd5,  3'd1, 16'd0,      1'b1, 1'b0, 4};
    vt[2]  = '{3'd1, 16'd2,     16'd3,      1'b1, 16'd3,  16'd2,  3'd1, 16'hFFFF,   1'b0, 1'b0, 4};
    vt[3]  = '{3'd3, 16'd100,   16'd7,      1'b1, 16'd100, 16'd7, 3'd3, 16'd14,     1'b0, 1'b0, 4};
    vt[4]  = '{3'd3, 16'd100,   16'd0,      1'b0, 16'd0,  16'd0,  3'd0, 16'hFFFF,   1'b0, 1'b1, 1};
    vt[5]  = '{3'd7, 16'd1,     16'd2,      1'b0, 16'd0,  16'd0,  3'd0, 16'hFFFF,   1'b0, 1'b1, 1};
    vt[6]  = '{3'd4, 16'h1234,  16'h5555,   1'b1, 16'd0,  16'h1234, 3'd4, 16'h1234, 1'b0, 1'b0, 4};
    vt[7]  = '{3'd0, 16'hFFFF,  16'd1,      1'b1, 16'hFFFF, 16'd1, 3'd0, 16'd0,     1'b1, 1'b0, 4};
    vt[8]  = '{3'd6, 16'd9,     16'd9,      1'b0, 16'd0,  16'd0,  3'd0, 16'hFFFF,   1'b0, 1'b1, 1};
    vt[9]  = '{3'd3, 16'd5,     16'd9,      1'b1, 16'd5,  16'd9,  3'd3, 16'd0,      1'b1, 1'b0, 4};
    vt[10] = '{3'd2, 16'd7,     16'd8,      1'b1, 16'd7,  16'd8,  3'd2, 16'd56,     1'b0, 1'b0, 4};

    repeat (3) @(posedge clock);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_zero", rsp_zero, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_alu_in1", alu_in1, 0);
    check("rst_alu_in2", alu_in2, 0);
    check("rst_alu_op", alu_op, 0);
    reset = 1'b0;
    @(posedge clock);
    #1 check("rst_release_ready", cmd_ready, 1);

    for (int i = 0; i < 11; i++) begin
      p1 = alu_in1; p2 = alu_in2; pop = alu_op;
      sb.push_back('{vt[i].data, vt[i].zero, vt[i].err});
      send(vt[i].op, vt[i].a, vt[i].b, 1'b0);
      check($sformatf("v%0d_in1", i), alu_in1, vt[i].touch ? vt[i].in1 : p1);
      check($sformatf("v%0d_in2", i), alu_in2, vt[i].touch ? vt[i].in2 : p2);
      check($sformatf("v%0d_aop", i), alu_op, vt[i].touch ? vt[i].aop : pop);
      wait_rsp($sformatf("v%0d", i), lat);
      check($sformatf("v%0d_lat", i), lat, vt[i].lat);
    end

    // MAC chain (2,3),(4,5),(1,6,last): 6 + 20 + 6 = 32
    send(3'd5, 16'd2, 16'd3, 1'b0);
    check("mac0_aop", alu_op, 2);
    check("mac0_in1", alu_in1, 2);
    wait_ready("mac0", lat);
    check("mac0_ready_lat", lat, 5);
    check("mac0_no_rsp", rsp_valid, 0);
    send(3'd5, 16'd4, 16'd5, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("mac1_add_op", alu_op, 0);
    check("mac1_add_in1", alu_in1, 20);
    check("mac1_add_in2", alu_in2, 6);
    wait_ready("mac1", lat);
    check("mac1_ready_lat", lat, 3);
    sb.push_back('{16'd32, 1'b0, 1'b0});
    send(3'd5, 16'd1, 16'd6, 1'b1);
    wait_rsp("mac_last", lat);
    check("mac_last_lat", lat, 6);
    sb.push_back('{16'd0, 1'b1, 1'b0});
    send(3'd5, 16'd0, 16'd9, 1'b1);
    wait_rsp("mac_fresh", lat);
    check("mac_fresh_lat", lat, 6);

    // Backpressure with mul 300*300
    sb.push_back('{16'h5F90, 1'b0, 1'b0});
    send(3'd2, 16'd300, 16'd300, 1'b0);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clock);
      #1 lat++;
    end
    check("bp_lat", lat, 4);
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      check($sformatf("bp%0d_valid", k), rsp_valid, 1);
      check($sformatf("bp%0d_data", k), rsp_data, 16'h5F90);
      check($sformatf("bp%0d_ready", k), cmd_ready, 0);
    end
    wait_rsp("bp", lat);

    // Reset during W2 of a MAC step with acc=6
    send(3'd5, 16'd2, 16'd3, 1'b0);
    wait_ready("pre_rst", lat);
    send(3'd5, 16'd4, 16'd5, 1'b1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("mrst_valid", rsp_valid, 0);
    check("mrst_ready", cmd_ready, 0);
    check("mrst_data", rsp_data, 0);
    check("mrst_in1", alu_in1, 0);
    check("mrst_in2", alu_in2, 0);
    check("mrst_op", alu_op, 0);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      check($sformatf("mrst%0d_ready", k), cmd_ready, 1);
      check($sformatf("mrst%0d_norsp", k), rsp_valid, 0);
    end
    sb.push_back('{16'd10, 1'b0, 1'b0});
    send(3'd5, 16'd2, 16'd5, 1'b1);
    wait_rsp("post_rst_mac", lat);
    check("post_rst_lat", lat, 6);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
